// File: rtl/bfly_stage_seq_if.sv
// Control bundle between a stage requester and the butterfly stage sequencer.
// The sequencer takes the slave side; the requester and the RAM/butterfly take the master side.
interface bfly_stage_seq_if #(
    parameter int unsigned N_LOG2 = 4
);
    localparam int unsigned StageW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;

    logic              start;
    logic [StageW-1:0] stage;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr0;
    logic [N_LOG2-1:0] rd_addr1;
    logic              bf_en;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr0;
    logic [N_LOG2-1:0] wr_addr1;

    modport master (
        output start, stage,
        input  busy, done, rd_en, rd_addr0, rd_addr1, bf_en, wr_en, wr_addr0, wr_addr1
    );

    modport slave (
        input  start, stage,
        output busy, done, rd_en, rd_addr0, rd_addr1, bf_en, wr_en, wr_addr0, wr_addr1
    );
endinterface

// File: rtl/bfly_stage_seq.sv
// Address sequencer for one radix-2 FFT stage: issues N/2 read pairs, then
// delay-matches the strobes and addresses to the butterfly enable and write-back.
module bfly_stage_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_LOG2     = 4,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned BF_LAT     = 1
) (
    input logic             clk,
    input logic             rst,
    bfly_stage_seq_if.slave bus
);
    localparam int unsigned StageW  = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam int unsigned KW      = N_LOG2 - 1;
    localparam int unsigned PipeLat = RAM_LAT + BF_LAT;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    if (DATA_WIDTH == 0 || N_LOG2 < 2 || RAM_LAT < 1 || RAM_LAT > 3 ||
        BF_LAT < 1 || BF_LAT > 3) begin : g_param_check
        $error("bfly_stage_seq: parameter out of range");
    end

    logic [1:0]        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [StageW-1:0] stage_q, stage_d;
    logic [2:0]        drain_q, drain_d;
    logic              done_q, done_d;

    logic [PipeLat-1:0] vld_q;
    logic [N_LOG2-1:0]  a0_q [PipeLat];
    logic [N_LOG2-1:0]  a1_q [PipeLat];

    logic              rd_en;
    logic              wr_en;
    logic [N_LOG2-1:0] kk, span, mask, addr0, addr1;

    // Insert a zero at bit s of k: low bits stay, high bits shift up by one.
    always_comb begin
        kk    = N_LOG2'(k_q);
        span  = N_LOG2'(1) << stage_q;
        mask  = span - N_LOG2'(1);
        rd_en = (state_q == StRun);
        addr0 = '0;
        addr1 = '0;
        if (rd_en) begin
            addr0 = ((kk & ~mask) << 1) | (kk & mask);
            addr1 = addr0 | span;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    k_d     = '0;
                    stage_d = (32'(bus.stage) >= N_LOG2) ? StageW'(N_LOG2 - 1) : bus.stage;
                end
            end
            StRun: begin
                if (k_q == '1) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDrain: begin
                drain_d = drain_q + 3'd1;
                // Last drain cycle is the one carrying the final wr_en.
                if (32'(drain_q) == PipeLat - 1) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < PipeLat; i++) begin
                a0_q[i] <= '0;
                a1_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            vld_q   <= {vld_q[PipeLat-2:0], rd_en};
            a0_q[0] <= addr0;
            a1_q[0] <= addr1;
            for (int i = 1; i < PipeLat; i++) begin
                a0_q[i] <= a0_q[i-1];
                a1_q[i] <= a1_q[i-1];
            end
        end
    end

    assign wr_en        = vld_q[PipeLat-1];
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr0 = addr0;
    assign bus.rd_addr1 = addr1;
    assign bus.bf_en    = vld_q[RAM_LAT-1];
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr0 = wr_en ? a0_q[PipeLat-1] : '0;
    assign bus.wr_addr1 = wr_en ? a1_q[PipeLat-1] : '0;
endmodule

// File: tb/tb_bfly_stage_seq.sv
// Directed bench for bfly_stage_seq: default-latency instance plus a RAM_LAT=2/BF_LAT=2 instance.
module tb_bfly_stage_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bfly_stage_seq_if #(.N_LOG2(4)) ifa ();
    bfly_stage_seq_if #(.N_LOG2(4)) ifb ();

    bfly_stage_seq #(.DATA_WIDTH(16), .N_LOG2(4), .RAM_LAT(1), .BF_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    bfly_stage_seq #(.DATA_WIDTH(16), .N_LOG2(4), .RAM_LAT(2), .BF_LAT(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        logic [1:0]  stage;
        logic [31:0] a0;  // nibble i = rd_addr0 of pair k=i
        logic [31:0] a1;
    } vec_t;

    vec_t vecs[4];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk1(input string name, input int cyc, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk4(input string name, input int cyc, input logic [3:0] act,
                        input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [31:0] w, input int i);
        return w[4*i +: 4];
    endfunction

    task automatic smp(input bit sel, output logic busy, output logic done, output logic rd,
                       output logic bf, output logic wr, output logic [3:0] r0,
                       output logic [3:0] r1, output logic [3:0] w0, output logic [3:0] w1);
        if (sel) begin
            busy = ifb.busy; done = ifb.done; rd = ifb.rd_en; bf = ifb.bf_en; wr = ifb.wr_en;
            r0 = ifb.rd_addr0; r1 = ifb.rd_addr1; w0 = ifb.wr_addr0; w1 = ifb.wr_addr1;
        end else begin
            busy = ifa.busy; done = ifa.done; rd = ifa.rd_en; bf = ifa.bf_en; wr = ifa.wr_en;
            r0 = ifa.rd_addr0; r1 = ifa.rd_addr1; w0 = ifa.wr_addr0; w1 = ifa.wr_addr1;
        end
    endtask

    // Cycle c counts from the first busy cycle. Called and returns at a negedge.
    task automatic run_stage(input bit sel, input logic [1:0] s, input logic [31:0] ea0,
                             input logic [31:0] ea1, input int rl, input int bl,
                             input bit already, input int poke, input int chain,
                             input int rst_at);
        int   lat  = rl + bl;
        int   last = (chain >= 0) ? 9 + lat : 10 + lat;
        logic busy, done, rd, bf, wr;
        logic [3:0] r0, r1, w0, w1;
        logic erd, ebf, ewr;
        if (!already) begin
            if (sel) begin ifb.start = 1'b1; ifb.stage = s; end
            else begin ifa.start = 1'b1; ifa.stage = s; end
        end
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            ifb.start = 1'b0;
            smp(sel, busy, done, rd, bf, wr, r0, r1, w0, w1);
            erd = (c <= 8);
            ebf = (c - rl >= 1) && (c - rl <= 8);
            ewr = (c - lat >= 1) && (c - lat <= 8);
            chk1("busy", c, busy, c <= 8 + lat);
            chk1("done", c, done, c == 9 + lat);
            chk1("rd_en", c, rd, erd);
            chk4("rd_addr0", c, r0, erd ? nib(ea0, c - 1) : 4'h0);
            chk4("rd_addr1", c, r1, erd ? nib(ea1, c - 1) : 4'h0);
            chk1("bf_en", c, bf, ebf);
            chk1("wr_en", c, wr, ewr);
            chk4("wr_addr0", c, w0, ewr ? nib(ea0, c - lat - 1) : 4'h0);
            chk4("wr_addr1", c, w1, ewr ? nib(ea1, c - lat - 1) : 4'h0);
            if (c == poke) begin
                ifa.start = 1'b1;
                ifa.stage = 2'd1;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                break;
            end
            if (chain >= 0 && c == 9 + lat) begin
                ifa.start = 1'b1;
                ifa.stage = 2'(chain);
            end
        end
        if (rst_at > 0) begin
            @(negedge clk);
            smp(sel, busy, done, rd, bf, wr, r0, r1, w0, w1);
            rst = 1'b0;
            chk1("rst_busy", 0, busy, 1'b0);
            chk1("rst_done", 0, done, 1'b0);
            chk1("rst_rd_en", 0, rd, 1'b0);
            chk1("rst_bf_en", 0, bf, 1'b0);
            chk1("rst_wr_en", 0, wr, 1'b0);
            chk4("rst_wr_addr0", 0, w0, 4'h0);
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                smp(sel, busy, done, rd, bf, wr, r0, r1, w0, w1);
                chk1("post_rst_wr_en", j, wr, 1'b0);
                chk1("post_rst_done", j, done, 1'b0);
                chk1("post_rst_busy", j, busy, 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy, done, rd, bf, wr;
        logic [3:0] r0, r1, w0, w1;

        vecs[0] = '{stage: 2'd0, a0: 32'hECA8_6420, a1: 32'hFDB9_7531};
        vecs[1] = '{stage: 2'd1, a0: 32'hDC98_5410, a1: 32'hFEBA_7632};
        vecs[2] = '{stage: 2'd2, a0: 32'hBA98_3210, a1: 32'hFEDC_7654};
        vecs[3] = '{stage: 2'd3, a0: 32'h7654_3210, a1: 32'hFEDC_BA98};

        ifa.start = 1'b0; ifa.stage = 2'd0;
        ifb.start = 1'b0; ifb.stage = 2'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            smp(sel[0], busy, done, rd, bf, wr, r0, r1, w0, w1);
            chk1("reset_busy", 0, busy, 1'b0);
            chk1("reset_done", 0, done, 1'b0);
            chk1("reset_rd_en", 0, rd, 1'b0);
            chk1("reset_bf_en", 0, bf, 1'b0);
            chk1("reset_wr_en", 0, wr, 1'b0);
            chk4("reset_rd_addr0", 0, r0, 4'h0);
            chk4("reset_rd_addr1", 0, r1, 4'h0);
            chk4("reset_wr_addr0", 0, w0, 4'h0);
            chk4("reset_wr_addr1", 0, w1, 4'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_stage(1'b0, vecs[i].stage, vecs[i].a0, vecs[i].a1, 1, 1, 1'b0, 0, -1, 0);
        end

        // start while busy must be ignored
        run_stage(1'b0, 2'd0, vecs[0].a0, vecs[0].a1, 1, 1, 1'b0, 4, -1, 0);

        // reset on the 5th rd_en, then a clean full stage
        run_stage(1'b0, 2'd0, vecs[0].a0, vecs[0].a1, 1, 1, 1'b0, 0, -1, 5);
        run_stage(1'b0, 2'd2, vecs[2].a0, vecs[2].a1, 1, 1, 1'b0, 0, -1, 0);

        // back-to-back: restart on the done cycle with stage 1
        run_stage(1'b0, 2'd0, vecs[0].a0, vecs[0].a1, 1, 1, 1'b0, 0, 1, 0);
        run_stage(1'b0, 2'd1, vecs[1].a0, vecs[1].a1, 1, 1, 1'b1, 0, -1, 0);

        // longer pipeline instance, top stage
        run_stage(1'b1, 2'd3, vecs[3].a0, vecs[3].a1, 2, 2, 1'b0, 0, -1, 0);

        // rst wins over a simultaneous start
        ifa.start = 1'b1;
        ifa.stage = 2'd0;
        rst = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        rst = 1'b0;
        smp(1'b0, busy, done, rd, bf, wr, r0, r1, w0, w1);
        chk1("rst_prio_busy", 0, busy, 1'b0);
        chk1("rst_prio_rd_en", 0, rd, 1'b0);
        @(negedge clk);
        smp(1'b0, busy, done, rd, bf, wr, r0, r1, w0, w1);
        chk1("rst_prio_busy_next", 1, busy, 1'b0);
        chk1("rst_prio_rd_en_next", 1, rd, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
